cp0_except_commit: RTL
======================

# cp0_except_commit

Coprocessor-0 register file and exception-commit unit for the MIPS pipeline. Consumes the 32-bit `excepttype` code produced by the memory-stage exception prioritiser, updates Status/Cause/EPC/BadVAddr, issues pipeline flush and redirect PC, and returns Status/Cause back to the prioritiser for interrupt qualification. Also hosts MTC0/MFC0 access and the Count/Compare timer.

## Interface
- `EXC_VECTOR`, 32'hBFC0_0380, redirect target for all non-ERET exceptions
- `STATUS_RST`, 32'h0040_0000, Status reset value (BEV=1)

- `clk` in 1: rising-edge clock
- `rst` in 1: reset rst, synchronous, active-high
- `excepttype_i` in 32: 0 none; 1 Int; 4 AdEL; 5 AdES; 8 Sys; 9 Bp; 0xA RI; 0xC Ov; 0xE ERET
- `pc_i` in 32: PC of the committing instruction
- `in_delayslot_i` in 1: committing instruction sits in a branch delay slot
- `bad_addr_i` in 32: faulting address for AdEL/AdES
- `int_i` in 6: external hardware interrupt lines
- `we_i` in 1: MTC0 write enable
- `waddr_i` in 5: MTC0 register number
- `wdata_i` in 32: MTC0 data
- `raddr_i` in 5: MFC0 register number
- `rdata_o` out 32: MFC0 read data, combinational from registered state
- `status_o`, `cause_o`, `epc_o`, `badvaddr_o`, `count_o`, `compare_o` out 32 each: current register values
- `timer_int_o` out 1: timer interrupt pending
- `flush_o` out 1: flush the pipeline
- `newpc_o` out 32: redirect target, valid while `flush_o`=1

## Operation
- Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14). Any other `raddr_i` reads 0; writes to it are ignored.
- Reset values: Status=`STATUS_RST`; all other registers 0; `timer_int_o`=0.
- Exception commit (`excepttype_i` nonzero, not 0xE):
  - Cause.ExcCode[6:2] = 0 for code 1, otherwise `excepttype_i[4:0]`.
  - Status.EXL = 1.
  - If Status.EXL was 0: EPC = `pc_i` − 4 when `in_delayslot_i`, else `pc_i`; Cause.BD[31] = `in_delayslot_i`. If EXL was already 1, EPC and BD are left unchanged.
  - BadVAddr = `bad_addr_i` for codes 4 and 5 only.
  - `newpc_o` = `EXC_VECTOR`.
- ERET (0xE): Status.EXL = 0; `newpc_o` = EPC.
- `flush_o` = (`excepttype_i` != 0). It is combinational, in the same cycle.
- MTC0 write mask:
  - Status: bits [15:8], [1], [0] only.
  - Cause: bits [9:8] only.
  - EPC, Count, Compare: full word.
  - BadVAddr: read-only.
- Write to Compare clears `timer_int_o`.
- MTC0 is suppressed in any cycle where `excepttype_i` != 0. The excepting instruction is squashed.
- Cause.IP[15:10] is sampled every cycle as {`int_i[5]` | `timer_int_o`, `int_i[4:0]`}. It is not writable.

## Timing
- All register updates occur on the clock edge after the commit cycle.
- `status_o` and `cause_o` reflect the new values one cycle after the exception.
- A second exception in the very next cycle sees EXL=1 and therefore keeps the old EPC.
- `rdata_o` has no write forwarding: an MFC0 in the MTC0 cycle returns the old value.
- Exception priority over everything else in the same cycle: if an exception and an MTC0 occur together, only the exception takes effect.
- Count/Compare same-cycle events:
  - When an MTC0 to Count coincides with an increment, the written value wins.
  - When an MTC0 to Compare coincides with a match, the match is discarded (clear wins).
- `rst` asserted mid-operation restores every reset value on the next edge and drops the internal tick bit to 0.

## Configuration
- `CP0_TIMER_EN` defined (timer compiled in):
  - A 1-bit tick toggles every cycle. Count increments when tick=1, i.e. every second cycle, and wraps from 32'hFFFF_FFFF to 0.
  - `timer_int_o` is set on the edge after Count == Compare with Compare != 0. It stays set until Compare is written.
- `CP0_TIMER_EN` undefined (timer compiled out):
  - Count stays at its written value and never increments.
  - `timer_int_o` is tied to 0.
  - Cause.IP7 = `int_i[5]` only.

## Test plan
- Reset → Status=0x0040_0000, Cause/EPC/BadVAddr/Count/Compare=0, `flush_o`=0.
- excepttype=4, pc=0xBFC0_0100, delayslot=1, bad_addr=0x1233 → `flush_o`=1, `newpc_o`=0xBFC0_0380. Next cycle: EPC=0xBFC0_00FC, Cause.BD=1, ExcCode=4, BadVAddr=0x1233, EXL=1.
- Exception with EXL=1 (excepttype=8, pc=0x100) → EPC unchanged, ExcCode=8. Then ERET → `newpc_o`=old EPC and EXL=0 one cycle later.
- MTC0 Status=0xFFFF_FFFF → Status=0x0040_FF03. The same MTC0 with excepttype=0xC in that cycle → Status unchanged apart from EXL=1.
- `CP0_TIMER_EN`: Compare=5, Count=0 → `timer_int_o` rises after Count reaches 5 (about 10 cycles) and Cause[15]=1. MTC0 Compare → `timer_int_o`=0 next cycle.
- `int_i`=6'b000001, Status.IM2=1, IE=1 → Cause[10]=1 next cycle. MFC0 Cause returns 0x0000_0400.

Source files
------------

// File: rtl/cp0_except_commit.sv
// -----------------------------------------------------------------------------
// cp0_except_commit
//
// Coprocessor-0 register file and exception-commit unit. Takes the exception
// code chosen by the memory-stage prioritiser, commits it into
// Status/Cause/EPC/BadVAddr, raises a pipeline flush with a redirect PC, and
// hosts MTC0/MFC0 access plus the optional Count/Compare timer.
//
// Build option:
//   CP0_TIMER_EN  defined   -> Count increments every second cycle and the
//                              Count/Compare timer interrupt is generated.
//                 undefined -> Count holds its written value, timer_int_o = 0.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   excepttype_i [31:0]   0 none, 1 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp,
//                         0xA RI, 0xC Ov, 0xE ERET
//   pc_i [31:0]           PC of the committing instruction
//   in_delayslot_i        committing instruction sits in a delay slot
//   bad_addr_i [31:0]     faulting address for AdEL/AdES
//   int_i [5:0]           external hardware interrupt lines
//   we_i, waddr_i, wdata_i   MTC0 write port
//   raddr_i, rdata_o         MFC0 read port (no write forwarding)
//   status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  register values
//   timer_int_o           Count/Compare interrupt pending
//   flush_o, newpc_o      pipeline flush and redirect target (same cycle)
// -----------------------------------------------------------------------------
module cp0_except_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  typedef enum logic [4:0] {
    CP0_BADVADDR = 5'd8,
    CP0_COUNT    = 5'd9,
    CP0_COMPARE  = 5'd11,
    CP0_STATUS   = 5'd12,
    CP0_CAUSE    = 5'd13,
    CP0_EPC      = 5'd14
  } cp0_reg_e;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  // Software-writable fields: Status IM[15:8], EXL, IE; Cause IP[9:8].
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;

  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] cause_d;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_int_q;
  logic [5:0]  ip_sample;

  // ---------------------------------------------------------------------------
  // Commit decode
  // ---------------------------------------------------------------------------
  logic        exc_any;
  logic        is_eret;
  logic        is_exc;
  logic        is_addr_exc;
  logic        mtc0_en;
  logic        exl;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;

  assign exc_any     = (excepttype_i != 32'd0);
  assign is_eret     = (excepttype_i == EXC_ERET);
  assign is_exc      = exc_any && !is_eret;
  assign is_addr_exc = (excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES);
  assign exl         = status_q[STATUS_EXL];

  // The interrupt pseudo-code 1 is architecturally ExcCode 0.
  assign exc_code    = (excepttype_i == EXC_INT) ? 5'd0 : excepttype_i[4:0];

  // A delay-slot fault restarts at the branch, one word earlier.
  assign exc_epc     = in_delayslot_i ? (pc_i - 32'd4) : pc_i;

  // Any exception (including ERET) squashes the MTC0 of the same instruction.
  assign mtc0_en     = we_i && !exc_any;

  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;

  assign wr_count   = mtc0_en && (waddr_i == CP0_COUNT);
  assign wr_compare = mtc0_en && (waddr_i == CP0_COMPARE);
  assign wr_status  = mtc0_en && (waddr_i == CP0_STATUS);
  assign wr_cause   = mtc0_en && (waddr_i == CP0_CAUSE);
  assign wr_epc     = mtc0_en && (waddr_i == CP0_EPC);

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register in
  // the unit samples pre-edge values and simulation order cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
    end else if (is_exc) begin
      status_q[STATUS_EXL] <= 1'b1;
    end else if (is_eret) begin
      status_q[STATUS_EXL] <= 1'b0;
    end else if (wr_status) begin
      status_q <= (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
    end
  end

  // ---------------------------------------------------------------------------
  // Cause: IP[15:10] follows the interrupt lines every cycle; BD and ExcCode
  // are written by exception commit; IP[9:8] are software interrupts.
  // ---------------------------------------------------------------------------
  // NOTE: every field of cause_d gets its default before the conditional
  // updates, so no path through this block can infer a latch.
  always_comb begin
    cause_d         = cause_q;
    cause_d[15:10]  = ip_sample;
    if (is_exc) begin
      cause_d[6:2] = exc_code;
      if (!exl) begin
        cause_d[CAUSE_BD] = in_delayslot_i;
      end
    end else if (wr_cause) begin
      cause_d = (cause_d & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= 32'd0;
    end else begin
      cause_q <= cause_d;
    end
  end

  // ---------------------------------------------------------------------------
  // EPC: a nested exception (EXL already set) must keep the original return
  // address so the outer handler can still ERET correctly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= 32'd0;
    end else if (is_exc && !exl) begin
      epc_q <= exc_epc;
    end else if (wr_epc) begin
      epc_q <= wdata_i;
    end
  end

  // BadVAddr is read-only to software; only address errors load it.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= 32'd0;
    end else if (is_exc && is_addr_exc) begin
      badvaddr_q <= bad_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= 32'd0;
    end else if (wr_compare) begin
      compare_q <= wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Count / timer
  // ---------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
  logic tick_q;
  logic count_match;

  // Compare == 0 is treated as "timer disarmed".
  assign count_match = (compare_q != 32'd0) && (count_q == compare_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= 1'b0;
      count_q     <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      tick_q <= ~tick_q;

      // A software write takes precedence over the half-rate increment.
      if (wr_count) begin
        count_q <= wdata_i;
      end else if (tick_q) begin
        count_q <= count_q + 32'd1;
      end

      // Writing Compare acknowledges the interrupt, even against a match.
      if (wr_compare) begin
        timer_int_q <= 1'b0;
      end else if (count_match) begin
        timer_int_q <= 1'b1;
      end
    end
  end

  assign ip_sample = {int_i[5] | timer_int_q, int_i[4:0]};
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
    end else if (wr_count) begin
      count_q <= wdata_i;
    end
  end

  assign timer_int_q = 1'b0;
  assign ip_sample   = int_i;
`endif

  // ---------------------------------------------------------------------------
  // MFC0 read: purely from registered state, so a same-cycle MTC0 is not seen.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badvaddr_q;
      CP0_COUNT:    rdata_o = count_q;
      CP0_COMPARE:  rdata_o = compare_q;
      CP0_STATUS:   rdata_o = status_q;
      CP0_CAUSE:    rdata_o = cause_q;
      CP0_EPC:      rdata_o = epc_q;
      default:      rdata_o = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Flush / redirect
  // ---------------------------------------------------------------------------
  assign flush_o     = exc_any;
  assign newpc_o     = is_eret ? epc_q : EXC_VECTOR;

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule
